// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and types for the write arbiter and scanout logic.
package fb_pkg;
  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_ADDR_W = 17;

  typedef logic [7:0] rgb332_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VBL,
    CLEAR
  } fb_arb_state_t;
endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to a linear framebuffer address and flags off-screen pixels.
module fb_addr_calc #(
  parameter int unsigned FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int unsigned ADDR_W    = fb_pkg::FB_ADDR_W,
  parameter int unsigned X_W       = 9,
  parameter int unsigned Y_W       = 8
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  always_comb begin
    addr     = ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
    in_range = (32'(x) < FB_WIDTH) && (32'(y) < FB_HEIGHT);
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between the rasterizer pixel stream and a
// full-screen clear engine that can optionally wait for vertical blank.
module fb_write_arbiter #(
  parameter int unsigned FB_WIDTH   = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT  = fb_pkg::FB_HEIGHT,
  parameter int unsigned ADDR_W     = fb_pkg::FB_ADDR_W,
  parameter int unsigned SYNC_CLEAR = 1
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [8:0]        px_x,
  input  logic [7:0]        px_y,
  input  logic [7:0]        px_color,
  input  logic              clear_req,
  input  logic [7:0]        clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              vblank_start,
  output logic              fb_wea,
  output logic [ADDR_W-1:0] fb_addra,
  output logic [7:0]        fb_dina,
  output logic [15:0]       drop_cnt
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  fb_arb_state_t     r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  rgb332_t           r_clr_color;

  logic              w_hs;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_px_addr;

  fb_addr_calc #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT),
    .ADDR_W   (ADDR_W),
    .X_W      (9),
    .Y_W      (8)
  ) u_addr_calc (
    .x       (px_x),
    .y       (px_y),
    .addr    (w_px_addr),
    .in_range(w_in_range)
  );

  // Ready is gated by arstn so upstream never sees a handshake during reset.
  assign px_ready   = (r_state != CLEAR) && arstn;
  assign w_hs       = px_valid && px_ready;
  assign clear_busy = (r_state != IDLE);

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state     <= IDLE;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
      clear_done  <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_clr_color <= clear_color;
            r_state     <= (SYNC_CLEAR != 0) ? WAIT_VBL : CLEAR;
          end
        end
        WAIT_VBL: begin
          if (vblank_start) r_state <= CLEAR;
        end
        CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_clr_addr <= '0;
            r_state    <= IDLE;
            clear_done <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Clear and pixel writes are exclusive: px_ready is low for the whole CLEAR state.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      fb_wea   <= 1'b0;
      fb_addra <= '0;
      fb_dina  <= '0;
    end else begin
      fb_wea <= 1'b0;
      if (r_state == CLEAR) begin
        fb_wea   <= 1'b1;
        fb_addra <= r_clr_addr;
        fb_dina  <= r_clr_color;
      end else if (w_hs && w_in_range) begin
        fb_wea   <= 1'b1;
        fb_addra <= w_px_addr;
        fb_dina  <= px_color;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      drop_cnt <= '0;
    end else if (w_hs && !w_in_range && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: full-size geometry for addressing/drop checks,
// reduced 16x8 geometry (both clear modes) to keep full clears short.
module tb_fb_write_arbiter;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic        px_valid = 1'b0;
  logic [8:0]  px_x = '0;
  logic [7:0]  px_y = '0;
  logic [7:0]  px_color = '0;
  logic        clear_req = 1'b0;
  logic [7:0]  clear_color = '0;
  logic        vblank_start = 1'b0;

  // index 0: 320x240 SYNC_CLEAR=0, 1: 16x8 SYNC_CLEAR=0, 2: 16x8 SYNC_CLEAR=1
  logic        rdy[3];
  logic        busy[3];
  logic        done[3];
  logic        wea[3];
  logic [16:0] addr[3];
  logic [7:0]  din[3];
  logic [15:0] drop[3];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  fb_write_arbiter #(.SYNC_CLEAR(0)) u_big (
    .aclk(aclk), .arstn(arstn), .px_valid(px_valid), .px_ready(rdy[0]),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(busy[0]), .clear_done(done[0]),
    .vblank_start(vblank_start), .fb_wea(wea[0]), .fb_addra(addr[0]),
    .fb_dina(din[0]), .drop_cnt(drop[0])
  );

  fb_write_arbiter #(.FB_WIDTH(16), .FB_HEIGHT(8), .ADDR_W(17), .SYNC_CLEAR(0)) u_s0 (
    .aclk(aclk), .arstn(arstn), .px_valid(px_valid), .px_ready(rdy[1]),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(busy[1]), .clear_done(done[1]),
    .vblank_start(vblank_start), .fb_wea(wea[1]), .fb_addra(addr[1]),
    .fb_dina(din[1]), .drop_cnt(drop[1])
  );

  fb_write_arbiter #(.FB_WIDTH(16), .FB_HEIGHT(8), .ADDR_W(17), .SYNC_CLEAR(1)) u_s1 (
    .aclk(aclk), .arstn(arstn), .px_valid(px_valid), .px_ready(rdy[2]),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(busy[2]), .clear_done(done[2]),
    .vblank_start(vblank_start), .fb_wea(wea[2]), .fb_addra(addr[2]),
    .fb_dina(din[2]), .drop_cnt(drop[2])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard for the full-size instance: one entry per handshake, due one cycle later.
  typedef struct {
    int unsigned due;
    logic        wea;
    logic [16:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_en = 1'b0;

  always @(negedge aclk) begin
    exp_t e;
    if (sb_en) begin
      if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        if (e.wea) chk("sb_write", {wea[0], addr[0], din[0]}, {1'b1, e.addr, e.data});
        else       chk("sb_nowrite", wea[0], 1'b0);
      end else if (wea[0]) begin
        chk("sb_unexpected_write", wea[0], 1'b0);
      end
    end
  end

  task automatic do_reset;
    sb_en        = 1'b0;
    px_valid     = 1'b0;
    clear_req    = 1'b0;
    vblank_start = 1'b0;
    arstn        = 1'b0;
    tick();
    arstn = 1'b1;
    tick();
    sb_q.delete();
  endtask

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [7:0]  c;
    logic        wea;
    logic [16:0] addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{9'd5,   8'd3,   8'hE0, 1'b1, 17'd965};
    vecs[1] = '{9'd319, 8'd239, 8'h5A, 1'b1, 17'd76799};
    vecs[2] = '{9'd0,   8'd0,   8'h12, 1'b1, 17'd0};
    vecs[3] = '{9'd320, 8'd0,   8'hFF, 1'b0, 17'd0};
    vecs[4] = '{9'd319, 8'd0,   8'h34, 1'b1, 17'd319};
    vecs[5] = '{9'd0,   8'd240, 8'h77, 1'b0, 17'd0};
    vecs[6] = '{9'd0,   8'd239, 8'h81, 1'b1, 17'd76480};
    vecs[7] = '{9'd160, 8'd120, 8'hC3, 1'b1, 17'd38560};

    // Reset values while arstn is held low
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ctrl", {rdy[k], busy[k], done[k], wea[k]}, 4'b0000);
      chk("reset_data", {addr[k], din[k], drop[k]}, 41'd0);
    end
    tick();
    arstn = 1'b1;
    tick();

    // Pixel addressing and off-screen drops on full-size geometry
    sb_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      px_valid = 1'b1;
      px_x     = vecs[i].x;
      px_y     = vecs[i].y;
      px_color = vecs[i].c;
      chk("px_ready_idle", rdy[0], 1'b1);
      sb_q.push_back('{cyc + 1, vecs[i].wea, vecs[i].addr, vecs[i].c});
      tick();
    end
    px_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("drop_cnt_two", drop[0], 16'd2);

    // Drop counter saturation
    px_valid = 1'b1;
    px_x     = 9'd320;
    px_y     = 8'd0;
    for (int i = 0; i < 65532; i++) tick();
    px_valid = 1'b0;
    chk("drop_cnt_fffe", drop[0], 16'hFFFE);
    px_valid = 1'b1;
    tick();
    px_valid = 1'b0;
    chk("drop_cnt_ffff", drop[0], 16'hFFFF);
    px_valid = 1'b1;
    tick();
    tick();
    px_valid = 1'b0;
    chk("drop_cnt_sat", drop[0], 16'hFFFF);
    px_valid = 1'b1;
    px_x     = 9'd7;
    px_color = 8'h11;
    sb_q.push_back('{cyc + 1, 1'b1, 17'd7, 8'h11});
    tick();
    px_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained_sat", 32'(sb_q.size()), 32'd0);

    // Immediate clear (16x8), pixel in the request cycle, pixel held through the clear
    do_reset();
    px_valid    = 1'b1;
    px_x        = 9'd5;
    px_y        = 8'd3;
    px_color    = 8'hE0;
    clear_req   = 1'b1;
    clear_color = 8'h01;
    chk("s0_ready_req", rdy[1], 1'b1);
    tick();
    clear_req = 1'b0;
    px_x      = 9'd2;
    px_y      = 8'd1;
    px_color  = 8'hAA;
    chk("s0_px_before_clear", {wea[1], addr[1], din[1], busy[1], rdy[1]},
        {1'b1, 17'd53, 8'hE0, 1'b1, 1'b0});
    for (int k = 0; k < 128; k++) begin
      tick();
      if (k == 50) begin
        clear_req   = 1'b1;
        clear_color = 8'hFF;
      end else begin
        clear_req = 1'b0;
      end
      chk("s0_clear_beat", {wea[1], addr[1], din[1], rdy[1], done[1]},
          {1'b1, 17'(k), 8'h01, (k == 127), (k == 127)});
    end
    tick();
    px_valid = 1'b0;
    chk("s0_held_px", {wea[1], addr[1], din[1], done[1], busy[1]},
        {1'b1, 17'd18, 8'hAA, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s0_after_clear", {wea[1], done[1], busy[1]}, 3'b000);
    end

    // Deferred clear (16x8): vblank in request cycle ignored, pixels flow while waiting
    do_reset();
    clear_req    = 1'b1;
    clear_color  = 8'h3C;
    vblank_start = 1'b1;
    tick();
    clear_req    = 1'b0;
    vblank_start = 1'b0;
    chk("s1_busy_wait", {busy[2], rdy[2]}, 2'b11);
    for (int i = 0; i < 100; i++) begin
      int unsigned xx, yy;
      xx       = i % 16;
      yy       = (i / 16) % 8;
      px_valid = 1'b1;
      px_x     = 9'(xx);
      px_y     = 8'(yy);
      px_color = 8'(i);
      tick();
      chk("s1_px_wait", {wea[2], addr[2], din[2], busy[2], rdy[2]},
          {1'b1, 17'(yy * 16 + xx), 8'(i), 1'b1, 1'b1});
    end
    px_valid     = 1'b0;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    chk("s1_enter_clear", {wea[2], busy[2], rdy[2]}, 3'b010);
    for (int k = 0; k < 128; k++) begin
      tick();
      if (k == 40) begin
        clear_req   = 1'b1;
        clear_color = 8'h99;
      end else begin
        clear_req = 1'b0;
      end
      chk("s1_clear_beat", {wea[2], addr[2], din[2], done[2]},
          {1'b1, 17'(k), 8'h3C, (k == 127)});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s1_after_clear", {wea[2], done[2], busy[2]}, 3'b000);
    end
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    chk("s1_vblank_idle", {busy[2], rdy[2]}, 2'b01);
    tick();
    chk("s1_vblank_idle_nowrite", {wea[2], busy[2]}, 2'b00);

    // Reset mid-clear on full-size geometry
    do_reset();
    px_valid = 1'b1;
    px_x     = 9'd0;
    px_y     = 8'd240;
    tick();
    px_valid = 1'b0;
    chk("big_drop_one", drop[0], 16'd1);
    clear_req   = 1'b1;
    clear_color = 8'h55;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 1001; i++) tick();
    chk("big_clear_1000", {wea[0], addr[0], din[0], busy[0]}, {1'b1, 17'd1000, 8'h55, 1'b1});
    #2;
    arstn = 1'b0;
    #1;
    chk("mid_reset_ctrl", {wea[0], busy[0], done[0], rdy[0]}, 4'b0000);
    chk("mid_reset_data", {addr[0], din[0], drop[0]}, 41'd0);
    tick();
    #3;
    arstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_reset_idle", {wea[0], done[0], busy[0], rdy[0]}, 4'b0001);
    end
    clear_req   = 1'b1;
    clear_color = 8'h66;
    tick();
    clear_req = 1'b0;
    tick();
    chk("restart_addr0", {wea[0], addr[0], din[0]}, {1'b1, 17'd0, 8'h66});
    tick();
    chk("restart_addr1", {wea[0], addr[0], din[0]}, {1'b1, 17'd1, 8'h66});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
Owns the single write port (wea/addra/dina) of the 320x240 RGB332 framebuffer.
Shares that port between two sources:
- the rasterizer pixel stream, a valid/ready (x, y, colour) interface;
- an internal screen-clear engine, which fills every address with one colour, optionally deferred to vertical blank.
Converts (x, y) to a linear address y*320 + x and drops off-screen pixels.
Sits between the rasterizer and the framebuffer, clocked by aclk.

Parameters:
FB_WIDTH, 320, framebuffer width in pixels
FB_HEIGHT, 240, framebuffer height in pixels
ADDR_W, 17, framebuffer address width
SYNC_CLEAR, 1, 1 = clear starts at next vblank_start; 0 = clear starts immediately

Ports:
aclk  in  1  system clock (100 MHz); all ports synchronous to it
arstn  in  1  reset, asynchronous, active-low
px_valid  in  1  rasterizer pixel valid
px_ready  out  1  arbiter can accept a pixel
px_x  in  9  pixel column
px_y  in  8  pixel row
px_color  in  8  RGB332 colour
clear_req  in  1  single-cycle pulse; request full-screen clear
clear_color  in  8  RGB332 clear colour, sampled with clear_req
clear_busy  out  1  clear pending or in progress
clear_done  out  1  one-cycle pulse after the last clear write
vblank_start  in  1  one-cycle pulse at start of vertical blank (aclk domain)
fb_wea  out  1  framebuffer write enable
fb_addra  out  ADDR_W  framebuffer write address
fb_dina  out  8  framebuffer write data
drop_cnt  out  16  count of dropped off-screen pixels, saturating

Behaviour:
- Reset (arstn low, asynchronous):
  - Outputs: fb_wea=0, fb_addra=0, fb_dina=0, clear_busy=0, clear_done=0, drop_cnt=0.
  - State: IDLE; clear address counter=0; latched clear colour=0.
  - px_ready is forced 0 while arstn is low.
- States:
  - IDLE. clear_req → WAIT_VBL if SYNC_CLEAR=1, else CLEAR. clear_color is latched on the clear_req cycle.
  - WAIT_VBL. Pixel path stays active. vblank_start → CLEAR.
  - CLEAR. One write per cycle at addr = counter and data = latched colour, fb_wea=1. After the write at FB_WIDTH*FB_HEIGHT-1 (76799), go to IDLE, reset the counter to 0, and pulse clear_done for 1 cycle on the following cycle.
- px_ready:
  - px_ready = (state != CLEAR) && arstn, combinational from state.
  - A handshake is px_valid && px_ready.
- Pixel write latency:
  - A handshake in cycle N produces registered fb_wea/fb_addra/fb_dina in cycle N+1.
  - addr = px_y*FB_WIDTH + px_x, computed with unsigned ADDR_W-bit arithmetic: (y<<8)+(y<<6)+x for the default width.
- Off-screen pixels:
  - Condition: px_x >= FB_WIDTH or px_y >= FB_HEIGHT.
  - The pixel is still accepted (handshake completes), but fb_wea=0 in N+1.
  - drop_cnt increments and saturates at 16'hFFFF.
- fb_wea: low in every cycle with no pixel write and no clear write.
- clear_busy: 1 in WAIT_VBL and CLEAR, combinational from state.
- Boundaries:
  - clear_req and a pixel handshake in the same IDLE cycle: the pixel is written in N+1. If SYNC_CLEAR=0, the first clear write (addr 0) is in N+2.
  - clear_req while clear_busy: ignored; the latched colour is unchanged (coalesced).
  - vblank_start in IDLE: no effect.
  - vblank_start and clear_req in the same cycle: the clear waits for the next vblank_start.
  - Reset mid-clear: clear aborts, no clear_done, state IDLE.
  - px_valid held during CLEAR: the pixel is held upstream. It is accepted the first cycle back in IDLE, which is the same cycle clear_done pulses.

Decomposition:
- Shared package fb_pkg:
  - FB_WIDTH, FB_HEIGHT, FB_PIXELS (76800), FB_ADDR_W.
  - typedef rgb332_t (logic [7:0]).
  - typedef enum fb_arb_state_t {IDLE, WAIT_VBL, CLEAR}.
- Sub-module fb_addr_calc, combinational: inputs x, y; outputs addr and in_range. Reused later by the read-side scanout logic.

Test Plan:
- SYNC_CLEAR=0, clear_req with clear_color=8'h01:
  - exactly 76800 consecutive fb_wea cycles, addresses 0..76799, data 8'h01;
  - clear_done pulses once, the cycle after addr 76799;
  - px_ready=0 throughout.
- Pixel (x=5, y=3, color=8'hE0) handshake at cycle N → cycle N+1 shows fb_wea=1, fb_addra=965, fb_dina=8'hE0. Also check (319, 239) → addr 76799.
- Off-screen pixels (320, 0) and (0, 240) → both accepted, no fb_wea, drop_cnt=2. Force 65537 drops → drop_cnt stays 16'hFFFF.
- SYNC_CLEAR=1:
  - clear_req, then 100 cycles of pixel writes → the pixels are written and clear_busy=1;
  - vblank_start → the clear write to addr 0 occurs in the next cycle;
  - a second clear_req mid-clear is ignored (still 76800 writes, one clear_done).
- px_valid held during a clear → px_ready=0 and no pixel write; the pixel is accepted in the clear_done cycle and written one cycle later.
- arstn pulsed low at clear address 1000:
  - immediately fb_wea=0, clear_busy=0, drop_cnt=0, and no clear_done;
  - after release, a new clear restarts at addr 0.
